// File: rtl/dmem_ctrl.sv
// Data-memory access controller between the EX/MEM register and the memory
// stage. It takes one load/store/halt request at a time, runs the multi-cycle
// stall/done handshake with memory, stalls upstream while an access is in
// flight and returns a one-cycle completion/error pulse to writeback.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_write,
  input  logic        req_halt,
  input  logic        flush,
  input  logic        mem_stall,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        mem_enable,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        dump,
  output logic        stall,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    HALT
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             drop;
  logic             lat_write;
  logic             squash;

  // Upstream is held for the whole time the controller is away from IDLE
  assign stall  = (state != IDLE);
  // A flush in the completing cycle squashes the response just like an earlier one
  assign squash = drop | flush;

  // Request sequencing, memory handshake and response generation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      drop       <= 1'b0;
      lat_write  <= 1'b0;
      mem_enable <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      dump       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      dump      <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            if (req_halt) begin
              dump  <= 1'b1;
              state <= HALT;
            end else if (req_addr[0]) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              mem_addr   <= req_addr;
              mem_wdata  <= req_wdata;
              lat_write  <= req_write;
              mem_enable <= 1'b1;
              mem_write  <= req_write;
              state      <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (flush) drop <= 1'b1;
          if (!mem_stall) begin
            mem_enable <= 1'b0;
            mem_write  <= 1'b0;
            if (mem_done) begin
              state     <= IDLE;
              drop      <= 1'b0;
              rsp_valid <= !squash;
              rsp_rdata <= (lat_write || squash) ? '0 : mem_rdata;
            end else begin
              state    <= WAIT;
              wait_cnt <= '0;
            end
          end
        end
        WAIT: begin
          if (flush) drop <= 1'b1;
          // done takes priority over an expiring timeout in the same cycle
          if (mem_done) begin
            state     <= IDLE;
            drop      <= 1'b0;
            rsp_valid <= !squash;
            rsp_rdata <= (lat_write || squash) ? '0 : mem_rdata;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state     <= IDLE;
            drop      <= 1'b0;
            rsp_valid <= !squash;
            rsp_err   <= !squash;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: directed request sequences with an expected
// response queue checked by a monitor on the falling clock edge.
module tb_dmem_ctrl;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_write;
  logic        req_halt;
  logic        flush;
  logic        mem_stall;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic        mem_enable;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        dump;
  logic        stall;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        halted;

  int   tests;
  int   fails;
  rsp_t exp_q[$];

  dmem_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_write  (req_write),
    .req_halt   (req_halt),
    .flush      (flush),
    .mem_stall  (mem_stall),
    .mem_done   (mem_done),
    .mem_rdata  (mem_rdata),
    .mem_enable (mem_enable),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .dump       (dump),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .halted     (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_enable"}, {15'd0, mem_enable}, 16'd0);
    chk({tag, "_mem_write"},  {15'd0, mem_write},  16'd0);
    chk({tag, "_mem_addr"},   mem_addr,            16'd0);
    chk({tag, "_mem_wdata"},  mem_wdata,           16'd0);
    chk({tag, "_dump"},       {15'd0, dump},       16'd0);
    chk({tag, "_stall"},      {15'd0, stall},      16'd0);
    chk({tag, "_rsp_valid"},  {15'd0, rsp_valid},  16'd0);
    chk({tag, "_rsp_rdata"},  rsp_rdata,           16'd0);
    chk({tag, "_rsp_err"},    {15'd0, rsp_err},    16'd0);
    chk({tag, "_halted"},     {15'd0, halted},     16'd0);
  endtask

  task automatic issue(input logic [15:0] addr, input logic [15:0] wdata,
                       input logic wr, input logic hlt);
    req_valid = 1'b1;
    req_addr  = addr;
    req_wdata = wdata;
    req_write = wr;
    req_halt  = hlt;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_halt  = 1'b0;
  endtask

  initial begin
    int   stall_n;
    int   wait_n;
    int   dump_n;
    rsp_t got_e;

    tests     = 0;
    fails     = 0;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_write = 1'b0;
    req_halt  = 1'b0;
    flush     = 1'b0;
    mem_stall = 1'b0;
    mem_done  = 1'b0;
    mem_rdata = '0;

    // response monitor and global watchdog run alongside the stimulus
    fork
      forever begin
        @(negedge clk);
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp: got rdata %h err %0b expected no response", rsp_rdata, rsp_err);
          end else begin
            got_e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, got_e.rdata);
            chk("rsp_err", {15'd0, rsp_err}, {15'd0, got_e.err});
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
      end
    join_none

    // reset state
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // aligned load, done in the third WAIT cycle
    issue(16'h0010, 16'h0000, 1'b0, 1'b0);
    exp_q.push_back('{rdata: 16'hBEEF, err: 1'b0});
    cyc();
    idle_req();
    chk("ld_enable", {15'd0, mem_enable}, 16'd1);
    chk("ld_write", {15'd0, mem_write}, 16'd0);
    chk("ld_addr", mem_addr, 16'h0010);
    stall_n = 0;
    for (int i = 0; i < 4; i++) begin
      mem_done  = (i == 3);
      mem_rdata = (i == 3) ? 16'hBEEF : 16'h0000;
      if (i == 1) chk("ld_wait_enable", {15'd0, mem_enable}, 16'd0);
      if (stall) stall_n++;
      cyc();
    end
    mem_done = 1'b0;
    chk("ld_stall_cycles", 16'(stall_n), 16'd4);
    chk("ld_stall_end", {15'd0, stall}, 16'd0);

    // store with mem_stall for two cycles
    issue(16'h0020, 16'h1234, 1'b1, 1'b0);
    exp_q.push_back('{rdata: 16'h0000, err: 1'b0});
    cyc();
    idle_req();
    for (int i = 0; i < 3; i++) begin
      mem_stall = (i < 2);
      mem_done  = (i == 2);
      chk("st_enable", {15'd0, mem_enable}, 16'd1);
      chk("st_write", {15'd0, mem_write}, 16'd1);
      chk("st_addr", mem_addr, 16'h0020);
      chk("st_wdata", mem_wdata, 16'h1234);
      cyc();
    end
    mem_stall = 1'b0;
    mem_done  = 1'b0;
    chk("st_stall_end", {15'd0, stall}, 16'd0);
    chk("st_enable_end", {15'd0, mem_enable}, 16'd0);
    chk("st_addr_hold", mem_addr, 16'h0020);

    // misaligned access: immediate error, no memory access, no stall
    issue(16'h0003, 16'h0000, 1'b0, 1'b0);
    exp_q.push_back('{rdata: 16'h0000, err: 1'b1});
    cyc();
    idle_req();
    chk("mis_stall", {15'd0, stall}, 16'd0);
    chk("mis_enable", {15'd0, mem_enable}, 16'd0);
    chk("mis_valid", {15'd0, rsp_valid}, 16'd1);
    cyc();

    // flush in IDLE: ignored, no response
    issue(16'h0030, 16'h0000, 1'b0, 1'b0);
    flush = 1'b1;
    cyc();
    idle_req();
    flush = 1'b0;
    chk("flush_idle_stall", {15'd0, stall}, 16'd0);
    cyc();

    // timeout: done never arrives
    issue(16'h0040, 16'h0000, 1'b0, 1'b0);
    exp_q.push_back('{rdata: 16'h0000, err: 1'b1});
    cyc();
    idle_req();
    cyc();
    wait_n = 0;
    while (stall && wait_n < 40) begin
      wait_n++;
      cyc();
    end
    chk("to_wait_cycles", 16'(wait_n), 16'd16);

    // next request accepted; minimum-latency completion
    issue(16'h0050, 16'h0000, 1'b0, 1'b0);
    exp_q.push_back('{rdata: 16'hA5A5, err: 1'b0});
    cyc();
    idle_req();
    mem_done  = 1'b1;
    mem_rdata = 16'hA5A5;
    chk("min_stall", {15'd0, stall}, 16'd1);
    cyc();
    mem_done = 1'b0;
    chk("min_stall_end", {15'd0, stall}, 16'd0);
    chk("min_valid", {15'd0, rsp_valid}, 16'd1);

    // flush mid-WAIT on a store: store completes, response suppressed
    issue(16'h0060, 16'h7777, 1'b1, 1'b0);
    cyc();
    idle_req();
    chk("fl_write", {15'd0, mem_write}, 16'd1);
    chk("fl_wdata", mem_wdata, 16'h7777);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    mem_done = 1'b1;
    cyc();
    mem_done = 1'b0;
    chk("fl_stall_end", {15'd0, stall}, 16'd0);
    chk("fl_no_valid", {15'd0, rsp_valid}, 16'd0);

    // back-to-back loads: second accepted in the first response cycle
    issue(16'h0070, 16'h0000, 1'b0, 1'b0);
    exp_q.push_back('{rdata: 16'h1111, err: 1'b0});
    cyc();
    issue(16'h0072, 16'h0000, 1'b0, 1'b0);
    mem_done  = 1'b1;
    mem_rdata = 16'h1111;
    cyc();
    mem_done = 1'b0;
    exp_q.push_back('{rdata: 16'h2222, err: 1'b0});
    chk("b2b_first_valid", {15'd0, rsp_valid}, 16'd1);
    cyc();
    idle_req();
    chk("b2b_second_stall", {15'd0, stall}, 16'd1);
    chk("b2b_second_addr", mem_addr, 16'h0072);
    mem_done  = 1'b1;
    mem_rdata = 16'h2222;
    cyc();
    mem_done = 1'b0;
    cyc();

    // halt: single dump pulse, sticky halted, permanent stall
    issue(16'h0000, 16'h0000, 1'b0, 1'b1);
    cyc();
    idle_req();
    chk("halt_dump", {15'd0, dump}, 16'd1);
    chk("halt_stall", {15'd0, stall}, 16'd1);
    issue(16'h0090, 16'h0000, 1'b0, 1'b0);
    dump_n = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (dump) dump_n++;
      chk("halt_stall_hold", {15'd0, stall}, 16'd1);
      chk("halt_halted", {15'd0, halted}, 16'd1);
      chk("halt_enable", {15'd0, mem_enable}, 16'd0);
    end
    idle_req();
    chk("halt_extra_dumps", 16'(dump_n), 16'd0);

    // reset clears HALT
    #1;
    rst = 1'b0;
    #1;
    chk_zero("rst_halt");
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // asynchronous reset during ACCESS: outputs clear without a clock edge
    issue(16'h0080, 16'hCAFE, 1'b1, 1'b0);
    cyc();
    idle_req();
    chk("ar_enable_pre", {15'd0, mem_enable}, 16'd1);
    #1;
    rst = 1'b0;
    #1;
    chk_zero("rst_access");
    @(negedge clk);
    rst = 1'b1;
    cyc();
    cyc();
    chk("post_rst_stall", {15'd0, stall}, 16'd0);

    cyc();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_rsp: got %0d outstanding expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller sitting between the EX/MEM pipeline register and the memory stage. It accepts one load, store or halt request per transaction from upstream and drives the memory stage's enable, write, address, data and dump inputs. It supports a multi-cycle data memory through a stall/done handshake and stalls the pipeline while an access is in flight. It returns load data and a completion/error pulse to the writeback path.

## Interface
Parameters:
- TIMEOUT, 15: maximum cycles spent in WAIT before the access is abandoned with an error.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low)
- req_valid  input  1  upstream presents a memory request
- req_addr  input  16  byte address
- req_wdata  input  16  store data
- req_write  input  1  1 = store, 0 = load
- req_halt  input  1  request is a halt; triggers a memory dump
- flush  input  1  squash current/in-flight request
- mem_stall  input  1  memory cannot accept the access this cycle
- mem_done  input  1  memory has completed the access
- mem_rdata  input  16  memory read data, valid with mem_done
- mem_enable  output  1  memory access enable (registered)
- mem_write  output  1  memory write strobe (registered)
- mem_addr  output  16  latched address
- mem_wdata  output  16  latched store data
- dump  output  1  memory dump request (registered, one-cycle pulse)
- stall  output  1  hold upstream; equals (state != IDLE)
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  16  load data; 0 for stores and errors
- rsp_err  output  1  qualifies rsp_valid: misaligned or timed-out access
- halted  output  1  sticky; set after dump issued

## Operation
- States: IDLE, ACCESS, WAIT, HALT.
- IDLE, req_valid & !flush:
  - req_halt: dump=1 next cycle, go HALT.
  - req_addr[0]=1: no memory access; next cycle rsp_valid=1, rsp_err=1, stay IDLE.
  - Otherwise: latch addr/wdata/write, go ACCESS.
- IDLE, req_valid & flush: request ignored, no response.
- ACCESS: mem_enable=1, mem_write=latched write.
  - mem_stall=1: stay, hold all memory outputs.
  - mem_stall=0 & mem_done=1: go IDLE, respond.
  - mem_stall=0 & mem_done=0: go WAIT with wait_cnt=0.
- WAIT: mem_enable=0, wait_cnt increments each cycle.
  - mem_done: go IDLE, respond.
  - wait_cnt==TIMEOUT without done: go IDLE with rsp_err=1.
- Response: rsp_valid=1 one cycle. rsp_rdata=mem_rdata captured on done for loads, 0 for stores.
- Flush while in ACCESS/WAIT: the access completes (a store is not cancelled), but a drop flag is set and rsp_valid is suppressed. The drop flag clears on return to IDLE.
- HALT: terminal until reset. stall=1, halted=1, dump pulses exactly once.
- mem_addr and mem_wdata hold their last latched values outside an access.

## Timing
- Reset (asynchronous, rst=0): state IDLE. All outputs 0, including mem_enable, mem_write, mem_addr, mem_wdata, dump, rsp_*, halted, counters, and the drop flag. Reset mid-access aborts immediately with no response.
- Request accepted at edge N (IDLE, stall=0): mem_enable high in cycle N+1.
- Minimum latency, mem_done in the first ACCESS cycle: rsp_valid in cycle N+2, and stall is high for one cycle only.
- A new request may be accepted in the same cycle rsp_valid is high.
- Upstream must hold req_* stable while stall=1. The request seen in IDLE is consumed exactly once.
- Misaligned request: rsp_valid/rsp_err in cycle N+1, and stall is never raised.
- Timeout: rsp_err asserts TIMEOUT+1 cycles after entering WAIT.
- mem_done arriving in the same cycle as timeout: done wins, no error.

## Test plan
- Aligned load: addr 0x0010 with memory returning 0xBEEF after 3 WAIT cycles -> stall high 4 cycles; rsp_valid=1, rsp_rdata=0xBEEF, rsp_err=0.
- Store with mem_stall high 2 cycles: addr 0x0020, data 0x1234 -> mem_enable/mem_write held for 3 cycles with addr and data stable; rsp_rdata=0.
- Misaligned: addr 0x0003 -> no mem_enable; rsp_valid=rsp_err=1 in the next cycle.
- Timeout with TIMEOUT=15: mem_done never asserted -> rsp_err after 16 WAIT cycles, controller returns to IDLE, and the next request is accepted.
- Flush mid-WAIT on a store: the store completes (mem_write pulse seen) but there is no rsp_valid. Back-to-back loads: the second request is accepted in the rsp_valid cycle of the first.
- Halt, then reset asserted mid-access: dump is a single pulse, halted=1, stall stays 1. On rst=0 during a later ACCESS, all outputs clear immediately without waiting for clk.
